spybuf_readout_ctrl: RTL and testbench

- Reader-side controller for a 1024-deep spy buffer RAM.
- The RAM is filled by the companion write-address generator, which provides a 10-bit write address plus a sticky overflow flag.
- On request, this block freezes the writer, captures where writing stopped, and reads the captured words out in chronological order (oldest first) over a valid/ready stream.
- It sits between the spy RAM read port and the board control/readout logic.

---
 rtl/spybuf_readout_ctrl.sv | 162 ++++++++++++++++
 tb/tb_spybuf_readout_ctrl.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spybuf_readout_ctrl.sv
// Spy buffer readout controller: freezes the writer, captures the fill level
// and streams the captured words out oldest-first over a valid/ready port.
module spybuf_readout_ctrl #(
    parameter int unsigned AW      = 10,
    parameter int unsigned DW      = 32,
    parameter int unsigned RAM_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_req,
    input  logic [AW-1:0] wr_addr,
    input  logic          wr_overflow,
    output logic          freeze,
    output logic [AW-1:0] ram_addr,
    output logic          ram_rd,
    input  logic [DW-1:0] ram_data,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    output logic          dout_last,
    input  logic          dout_ready,
    output logic [AW:0]   word_count,
    output logic          busy,
    output logic          done
);

    localparam int unsigned CW = AW + 1;
    localparam int unsigned LW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
    localparam logic [CW-1:0] FULL_CNT = {1'b1, {AW{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_FREEZE1, S_FREEZE2, S_ISSUE, S_WAIT, S_PRESENT, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] rem_q, rem_d;
    logic [LW-1:0] lat_q, lat_d;
    logic [CW-1:0] cap_cnt;
    logic [AW-1:0] cap_ptr;

    logic          freeze_d, busy_d, ram_rd_d, dout_valid_d, dout_last_d, done_d;
    logic [AW-1:0] ram_addr_d;
    logic [DW-1:0] dout_d;
    logic [CW-1:0] word_count_d;

    // State, pointers and all registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            rem_q      <= '0;
            lat_q      <= '0;
            freeze     <= 1'b0;
            busy       <= 1'b0;
            ram_rd     <= 1'b0;
            ram_addr   <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            word_count <= '0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rem_q      <= rem_d;
            lat_q      <= lat_d;
            freeze     <= freeze_d;
            busy       <= busy_d;
            ram_rd     <= ram_rd_d;
            ram_addr   <= ram_addr_d;
            dout       <= dout_d;
            dout_valid <= dout_valid_d;
            dout_last  <= dout_last_d;
            word_count <= word_count_d;
            done       <= done_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        rem_d        = rem_q;
        lat_d        = lat_q;
        freeze_d     = freeze;
        busy_d       = busy;
        ram_rd_d     = 1'b0;
        ram_addr_d   = ram_addr;
        dout_d       = dout;
        dout_valid_d = dout_valid;
        dout_last_d  = dout_last;
        word_count_d = word_count;
        done_d       = 1'b0;
        // Wrapped buffer: the oldest word sits at the write address
        cap_cnt      = wr_overflow ? FULL_CNT : CW'(wr_addr);
        cap_ptr      = wr_overflow ? wr_addr : '0;

        case (state_q)
            S_IDLE: begin
                if (start_req) begin
                    state_d  = S_FREEZE1;
                    freeze_d = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            // One settle cycle so a write in flight lands before capture
            S_FREEZE1: state_d = S_FREEZE2;
            S_FREEZE2: begin
                word_count_d = cap_cnt;
                rem_d        = cap_cnt;
                ptr_d        = cap_ptr;
                if (cap_cnt == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d    = S_ISSUE;
                    ram_rd_d   = 1'b1;
                    ram_addr_d = cap_ptr;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                lat_d   = '0;
            end
            S_WAIT: begin
                if (lat_q == LW'(RAM_LAT - 1)) begin
                    state_d      = S_PRESENT;
                    dout_d       = ram_data;
                    dout_valid_d = 1'b1;
                    dout_last_d  = (rem_q == CW'(1));
                end else begin
                    lat_d = lat_q + LW'(1);
                end
            end
            S_PRESENT: begin
                if (dout_ready) begin
                    dout_valid_d = 1'b0;
                    dout_last_d  = 1'b0;
                    ptr_d        = ptr_q + AW'(1);
                    if (rem_q != '0) begin
                        rem_d = rem_q - CW'(1);
                    end
                    if (rem_q <= CW'(1)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = S_ISSUE;
                        ram_rd_d   = 1'b1;
                        ram_addr_d = ptr_q + AW'(1);
                    end
                end
            end
            S_DONE: begin
                state_d  = S_IDLE;
                freeze_d = 1'b0;
                busy_d   = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_spybuf_readout_ctrl.sv
// Directed testbench for spybuf_readout_ctrl (RAM_LAT=1 main instance, RAM_LAT=3 side instance).
module tb_spybuf_readout_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_req, start_req3;
    logic [9:0]  wr_addr;
    logic        wr_overflow;
    logic        freeze, ram_rd, dout_valid, dout_last, busy, done, dout_ready;
    logic [9:0]  ram_addr;
    logic [31:0] ram_data, dout;
    logic [10:0] word_count;
    logic        freeze3, ram_rd3, dout_valid3, dout_last3, busy3, done3, dout_ready3;
    logic [9:0]  ram_addr3;
    logic [31:0] ram_data3, dout3;
    logic [10:0] word_count3;
    logic [31:0] pipe3 [0:2];

    int checks = 0;
    int errors = 0;

    logic [9:0]  rd_addrs [$];
    logic [31:0] words [$];
    bit          lasts [$];
    int          done_cnt;
    bit          timed_out, stall_bad, rd_in_stall;

    always #5 clk = ~clk;

    spybuf_readout_ctrl #(.AW(10), .DW(32), .RAM_LAT(1)) u_dut (
        .clk(clk), .reset(reset), .start_req(start_req), .wr_addr(wr_addr),
        .wr_overflow(wr_overflow), .freeze(freeze), .ram_addr(ram_addr), .ram_rd(ram_rd),
        .ram_data(ram_data), .dout(dout), .dout_valid(dout_valid), .dout_last(dout_last),
        .dout_ready(dout_ready), .word_count(word_count), .busy(busy), .done(done)
    );

    spybuf_readout_ctrl #(.AW(10), .DW(32), .RAM_LAT(3)) u_dut3 (
        .clk(clk), .reset(reset), .start_req(start_req3), .wr_addr(wr_addr),
        .wr_overflow(wr_overflow), .freeze(freeze3), .ram_addr(ram_addr3), .ram_rd(ram_rd3),
        .ram_data(ram_data3), .dout(dout3), .dout_valid(dout_valid3), .dout_last(dout_last3),
        .dout_ready(dout_ready3), .word_count(word_count3), .busy(busy3), .done(done3)
    );

    // Spy RAM contents are a fixed function of the address
    function automatic logic [31:0] mem_word(input logic [9:0] a);
        return {a, 12'hABC, ~a};
    endfunction

    // RAM models: data only meaningful exactly RAM_LAT cycles after ram_rd
    always @(posedge clk) begin
        ram_data <= ram_rd ? mem_word(ram_addr) : 32'hDEAD_BEEF;
        pipe3[0] <= ram_rd3 ? mem_word(ram_addr3) : 32'hDEAD_BEEF;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign ram_data3 = pipe3[2];

    // Pulse start_req for one cycle; called and returns at a falling edge
    task automatic pulse_start();
        start_req = 1'b1;
        @(negedge clk);
        start_req = 1'b0;
    endtask

    // Act as consumer until done, recording reads, words and handshake behaviour
    task automatic drain(input int max_cyc, input int stall_word, input int stall_len,
                         input int restart_at);
        int acc = 0;
        int stall_cnt = 0;
        bit stalled_prev = 1'b0;
        bit fin = 1'b0;
        logic [31:0] held = '0;
        rd_addrs.delete(); words.delete(); lasts.delete();
        done_cnt = 0; timed_out = 1'b0; stall_bad = 1'b0; rd_in_stall = 1'b0;
        for (int cyc = 0; cyc < max_cyc && !fin; cyc++) begin
            start_req = (cyc == restart_at);
            if (cyc == restart_at) wr_addr = 10'd9;
            if (ram_rd) begin
                rd_addrs.push_back(ram_addr);
                if (stalled_prev) rd_in_stall = 1'b1;
            end
            if (stalled_prev && (!dout_valid || dout !== held)) stall_bad = 1'b1;
            stalled_prev = 1'b0;
            if (done) begin
                done_cnt++;
                fin = 1'b1;
            end
            if (dout_valid && acc == stall_word && stall_cnt < stall_len) begin
                dout_ready = 1'b0;
                stall_cnt++;
                stalled_prev = 1'b1;
                held = dout;
            end else begin
                dout_ready = 1'b1;
                if (dout_valid) begin
                    words.push_back(dout);
                    lasts.push_back(dout_last);
                    acc++;
                end
            end
            @(negedge clk);
        end
        start_req = 1'b0;
        dout_ready = 1'b0;
        if (!fin) timed_out = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk); @(negedge clk);
        checks++;
        if ({freeze, busy, ram_rd, dout_valid, dout_last, done} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 000000", {freeze, busy, ram_rd, dout_valid, dout_last, done});
        end
        checks++;
        if (ram_addr !== 10'd0 || dout !== 32'd0 || word_count !== 11'd0) begin
            errors++;
            $display("FAIL reset_values: got addr=%0d dout=%h wc=%0d want 0 0 0", ram_addr, dout, word_count);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_no_wrap();
        int bad = 0;
        wr_addr = 10'd5; wr_overflow = 1'b0;
        pulse_start();
        checks++;
        if (freeze !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL no_wrap_freeze_on: got freeze=%b busy=%b want 1 1", freeze, busy);
        end
        drain(200, -1, 0, -1);
        checks++;
        if (timed_out || rd_addrs.size() != 5 || words.size() != 5) begin
            errors++;
            $display("FAIL no_wrap_counts: got to=%b rds=%0d words=%0d want 0 5 5", timed_out, rd_addrs.size(), words.size());
        end else begin
            for (int i = 0; i < 5; i++)
                if (rd_addrs[i] !== 10'(i) || words[i] !== mem_word(10'(i)) || lasts[i] !== (i == 4)) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL no_wrap_sequence: got %0d bad entries want 0", bad);
            end
        end
        checks++;
        if (word_count !== 11'd5 || done_cnt != 1) begin
            errors++;
            $display("FAIL no_wrap_wc_done: got wc=%0d done=%0d want 5 1", word_count, done_cnt);
        end
        checks++;
        if (freeze !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL no_wrap_release: got freeze=%b busy=%b done=%b want 0 0 0", freeze, busy, done);
        end
    endtask

    task automatic test_wrapped();
        int bad = 0;
        int first_bad = -1;
        logic [9:0] ea;
        wr_addr = 10'd1000; wr_overflow = 1'b1;
        pulse_start();
        drain(4000, -1, 0, -1);
        checks++;
        if (timed_out || word_count !== 11'd1024 || words.size() != 1024 || rd_addrs.size() != 1024) begin
            errors++;
            $display("FAIL wrap_counts: got to=%b wc=%0d words=%0d rds=%0d want 0 1024 1024 1024",
                     timed_out, word_count, words.size(), rd_addrs.size());
        end else begin
            for (int i = 0; i < 1024; i++) begin
                ea = 10'((1000 + i) % 1024);
                if (rd_addrs[i] !== ea || words[i] !== mem_word(ea) || lasts[i] !== (i == 1023)) begin
                    bad++;
                    if (first_bad < 0) first_bad = i;
                end
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL wrap_sequence: got %0d bad entries (first %0d) want 0", bad, first_bad);
            end
            checks++;
            if (words[1023] !== mem_word(10'd999)) begin
                errors++;
                $display("FAIL wrap_last_word: got %h want %h", words[1023], mem_word(10'd999));
            end
        end
    endtask

    task automatic test_empty();
        bit activity = 1'b0;
        wr_addr = 10'd0; wr_overflow = 1'b0;
        pulse_start();
        activity |= ram_rd | dout_valid;
        checks++;
        if (freeze !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL empty_c1: got freeze=%b busy=%b done=%b want 1 1 0", freeze, busy, done);
        end
        @(negedge clk);
        activity |= ram_rd | dout_valid;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL empty_c2_done: got %b want 0", done);
        end
        @(negedge clk);
        activity |= ram_rd | dout_valid;
        checks++;
        if (done !== 1'b1 || word_count !== 11'd0) begin
            errors++;
            $display("FAIL empty_c3: got done=%b wc=%0d want 1 0", done, word_count);
        end
        @(negedge clk);
        activity |= ram_rd | dout_valid;
        checks++;
        if (done !== 1'b0 || freeze !== 1'b0 || busy !== 1'b0 || activity) begin
            errors++;
            $display("FAIL empty_c4: got done=%b freeze=%b busy=%b act=%b want 0 0 0 0", done, freeze, busy, activity);
        end
    endtask

    task automatic test_backpressure();
        int bad = 0;
        wr_addr = 10'd6; wr_overflow = 1'b0;
        pulse_start();
        drain(300, 2, 10, -1);
        checks++;
        if (stall_bad || rd_in_stall || timed_out) begin
            errors++;
            $display("FAIL bp_stall: got unstable=%b rd_in_stall=%b to=%b want 0 0 0", stall_bad, rd_in_stall, timed_out);
        end
        checks++;
        if (words.size() != 6 || rd_addrs.size() != 6) begin
            errors++;
            $display("FAIL bp_counts: got words=%0d rds=%0d want 6 6", words.size(), rd_addrs.size());
        end else begin
            for (int i = 0; i < 6; i++)
                if (rd_addrs[i] !== 10'(i) || words[i] !== mem_word(10'(i)) || lasts[i] !== (i == 5)) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL bp_order: got %0d bad entries want 0", bad);
            end
        end
    endtask

    task automatic test_reset_mid();
        int acc = 0;
        int bad = 0;
        bit reached = 1'b0;
        wr_addr = 10'd8; wr_overflow = 1'b0;
        pulse_start();
        for (int cyc = 0; cyc < 60 && !reached; cyc++) begin
            if (dout_valid && acc == 2) begin
                dout_ready = 1'b0;
                reached = 1'b1;
            end else begin
                dout_ready = 1'b1;
                if (dout_valid) acc++;
                @(negedge clk);
            end
        end
        checks++;
        if (!reached || dout !== mem_word(10'd2)) begin
            errors++;
            $display("FAIL rstmid_word3: got reached=%b dout=%h want 1 %h", reached, dout, mem_word(10'd2));
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({freeze, busy, ram_rd, dout_valid, dout_last, done} !== 6'b0 ||
            ram_addr !== 10'd0 || dout !== 32'd0 || word_count !== 11'd0) begin
            errors++;
            $display("FAIL rstmid_outputs: got flags=%b addr=%0d dout=%h wc=%0d want all 0",
                     {freeze, busy, ram_rd, dout_valid, dout_last, done}, ram_addr, dout, word_count);
        end
        @(negedge clk);
        reset = 1'b0;
        dout_ready = 1'b0;
        wr_addr = 10'd4; wr_overflow = 1'b0;
        @(negedge clk);
        pulse_start();
        drain(200, -1, 0, -1);
        checks++;
        if (timed_out || words.size() != 4 || rd_addrs.size() != 4 || word_count !== 11'd4 || done_cnt != 1) begin
            errors++;
            $display("FAIL rstmid_restart: got to=%b words=%0d rds=%0d wc=%0d done=%0d want 0 4 4 4 1",
                     timed_out, words.size(), rd_addrs.size(), word_count, done_cnt);
        end else begin
            for (int i = 0; i < 4; i++)
                if (rd_addrs[i] !== 10'(i) || words[i] !== mem_word(10'(i))) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL rstmid_sequence: got %0d bad entries want 0", bad);
            end
        end
    endtask

    task automatic test_ignored_request();
        int bad = 0;
        bit saw_busy = 1'b0;
        wr_addr = 10'd4; wr_overflow = 1'b0;
        pulse_start();
        drain(200, -1, 0, 6);
        checks++;
        if (timed_out || words.size() != 4 || word_count !== 11'd4 || done_cnt != 1) begin
            errors++;
            $display("FAIL ign_counts: got to=%b words=%0d wc=%0d done=%0d want 0 4 4 1",
                     timed_out, words.size(), word_count, done_cnt);
        end else begin
            for (int i = 0; i < 4; i++)
                if (rd_addrs[i] !== 10'(i) || words[i] !== mem_word(10'(i))) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL ign_sequence: got %0d bad entries want 0", bad);
            end
        end
        for (int i = 0; i < 8; i++) begin
            saw_busy |= busy | freeze | ram_rd;
            @(negedge clk);
        end
        checks++;
        if (saw_busy || word_count !== 11'd4) begin
            errors++;
            $display("FAIL ign_no_restart: got busy_seen=%b wc=%0d want 0 4", saw_busy, word_count);
        end
    endtask

    task automatic test_ram_lat3();
        int vcyc [$];
        logic [31:0] w3 [$];
        bit l3 [$];
        bit fin = 1'b0;
        int bad = 0;
        wr_addr = 10'd3; wr_overflow = 1'b0;
        start_req3 = 1'b1;
        @(negedge clk);
        start_req3 = 1'b0;
        for (int cyc = 0; cyc < 100 && !fin; cyc++) begin
            if (dout_valid3) begin
                vcyc.push_back(cyc);
                w3.push_back(dout3);
                l3.push_back(dout_last3);
            end
            if (done3) fin = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (!fin || vcyc.size() != 3 || word_count3 !== 11'd3) begin
            errors++;
            $display("FAIL lat3_counts: got fin=%b words=%0d wc=%0d want 1 3 3", fin, vcyc.size(), word_count3);
        end else begin
            checks++;
            if (vcyc[1] - vcyc[0] != 5 || vcyc[2] - vcyc[1] != 5) begin
                errors++;
                $display("FAIL lat3_spacing: got %0d %0d want 5 5", vcyc[1] - vcyc[0], vcyc[2] - vcyc[1]);
            end
            for (int i = 0; i < 3; i++)
                if (w3[i] !== mem_word(10'(i)) || l3[i] !== (i == 2)) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL lat3_data: got %0d bad entries want 0", bad);
            end
        end
    endtask

    initial begin
        reset = 1'b1; start_req = 1'b0; start_req3 = 1'b0;
        wr_addr = '0; wr_overflow = 1'b0; dout_ready = 1'b0; dout_ready3 = 1'b1;
        @(negedge clk);
        test_reset();
        test_no_wrap();
        test_empty();
        test_wrapped();
        test_backpressure();
        test_reset_mid();
        test_ignored_request();
        test_ram_lat3();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
